dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory (u_dmem) between the CPU load/store port (port 0)
//  and a debug/loader port (port 1). The debug port is used by benches/boot logic to preload or dump memory.
//  Arbitrates one access per cycle and muxes requests onto the memory port.
//  Routes 1-cycle synchronous read data back to the port that issued the read.
//  Sits between u_datapath and u_dmem inside cpu.
// PARAMETERS
//  ADDR_WIDTH  11  word-address bits of dmem
//  DATA_WIDTH  32  data word width
//  MAX_WAIT    4   consecutive cycles debug may be denied before forced grant (1..15)
// PORTS
//  clk           in   1           clock clk, rising edge
//  reset         in   1           reset reset, synchronous, active-low
//  cpu_valid     in   1           CPU request valid
//  cpu_ready     out  1           CPU request accepted this cycle (when cpu_valid)
//  cpu_we        in   1           1=write, 0=read
//  cpu_addr      in   ADDR_WIDTH  word address
//  cpu_wdata     in   DATA_WIDTH  write data
//  cpu_wstrb     in   4           byte enables for writes
//  cpu_rvalid    out  1           read data valid (1 cycle after accepted read)
//  cpu_rdata     out  DATA_WIDTH  read data
//  dbg_valid/dbg_ready/dbg_we/dbg_addr/dbg_wdata/dbg_wstrb/dbg_rvalid/dbg_rdata  same as cpu_*
//  dbg_lock      in   1           with an accepted dbg access: hold ownership after it
//  mem_en        out  1           memory access strobe
//  mem_we        out  4           byte write enables (0 for reads)
//  mem_addr      out  ADDR_WIDTH  memory word address
//  mem_wdata     out  DATA_WIDTH  memory write data
//  mem_rdata     in   DATA_WIDTH  memory read data, valid 1 cycle after mem_en && mem_we==0
// BEHAVIOUR
//  - reset low: all *_ready, *_rvalid, mem_en = 0; mem_we = 0; rdata outputs = 0.
//    Internal state cleared: lock=0, wait_cnt=0, last_grant=CPU, rd_owner=NONE.
//    Reset asserted mid-access drops any pending read response.
//  - Handshake: accept = valid && ready. ready is combinational from current valids and state.
//    ready is never asserted for both ports in the same cycle. valid may not depend on ready.
//  - Accepted request drives mem_* combinationally in the same cycle.
//    mem_en=1; mem_we = we ? wstrb : 4'b0.
//  - Read latency 1: cycle after an accepted read, owner's rvalid=1 and rdata=mem_rdata.
//    The other port reads rvalid=0, rdata=0.
//    Writes produce no response. Back-to-back reads from either port are allowed (fully pipelined).
//  - States: UNLOCKED and DBG_LOCKED.
//    * UNLOCKED, only one port valid -> that port granted.
//    * UNLOCKED, both valid -> CPU granted (fixed priority), unless wait_cnt == MAX_WAIT,
//      in which case dbg is granted.
//    * wait_cnt increments when dbg_valid && !dbg_ready (saturates at MAX_WAIT).
//      It clears on any dbg accept or when dbg_valid is low.
//    * Accepted dbg access with dbg_lock=1 -> DBG_LOCKED.
//    * DBG_LOCKED: cpu_ready=0; dbg_ready=dbg_valid.
//      An accepted dbg access with dbg_lock=0 -> UNLOCKED. No timeout.
//  - last_grant is updated on every accept.
//  - No address range check; addresses wrap modulo 2^ADDR_WIDTH in dmem.
// CONFIGURATION
//  DMEM_ARB_RR_EN defined: UNLOCKED with both valid grants the port != last_grant (round-robin).
//    wait_cnt/MAX_WAIT logic is removed.
//  DMEM_ARB_RR_EN undefined: fixed priority with the MAX_WAIT starvation guard, as above.
//  Lock behaviour is identical in both modes.
// STRUCTURE
//  dmem_arb_pkg: owner encoding (OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_DBG=2'd2),
//    state encoding (ST_UNLOCKED, ST_DBG_LOCKED), WSTRB_W=4.
//  Sub-module dmem_arb_sel: combinational grant select from valids, state, wait_cnt, last_grant.
//    Outputs a one-hot grant.
//  Top level holds the state register, wait_cnt, last_grant, rd_owner pipeline register, and the muxes.
// TESTING
//  1) Reset: hold reset=0 for 3 cycles with both valid=1.
//     -> both ready=0, mem_en=0, rvalid=0 throughout.
//  2) CPU write addr 8, data C0DECAFE, wstrb F; then CPU read addr 8.
//     -> mem_we=F on the write; cpu_rvalid=1 with rdata=C0DECAFE one cycle after the read accept.
//  3) Both valid continuously, dbg read addr 3 (fixed priority, MAX_WAIT=4).
//     -> CPU granted 4 cycles, dbg granted on 5th; dbg_rvalid on 6th; pattern repeats.
//  4) Same as 3 with DMEM_ARB_RR_EN.
//     -> grants alternate CPU,DBG,CPU,DBG starting with DBG (last_grant=CPU after reset).
//  5) dbg writes addr 0..3 with dbg_lock=1,1,1,0 while cpu_valid=1.
//     -> cpu_ready=0 until cycle after 4th dbg accept, then CPU granted.
//  6) CPU read accepted, reset asserted next edge.
//     -> cpu_rvalid stays 0; no stale response after reset release.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Owner encoding is used both for the read-response owner and for the
// last-granted port; the debug struct gives checkers one place to look
// at all arbiter state.
package dmem_arb_pkg;

    localparam int WSTRB_W = 4;
    localparam int WAIT_W  = 4;   // wide enough for MAX_WAIT up to 15

    // Bit positions inside the one-hot grant vector
    localparam int GNT_CPU = 0;
    localparam int GNT_DBG = 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    typedef enum logic {
        ST_UNLOCKED   = 1'b0,
        ST_DBG_LOCKED = 1'b1
    } arb_state_t;

    // Snapshot of every piece of arbiter state, exported for observation.
    // wait_cnt reads as zero when the round-robin build is selected.
    typedef struct packed {
        arb_state_t          state;
        owner_t              last_grant;
        owner_t              rd_owner;
        logic [WAIT_W-1:0]   wait_cnt;
    } arb_debug_t;

endpackage

// File: rtl/dmem_arb_sel.sv
// Combinational grant selection for the data-memory arbiter.
// Produces a one-hot grant {dbg, cpu}; never both.
// Build option DMEM_ARB_RR_EN: when defined, contention is resolved by
// round-robin on last_grant; otherwise CPU has fixed priority and the
// debug port wins only once it has been starved (wait_cnt == MAX_WAIT).
module dmem_arb_sel
    import dmem_arb_pkg::*;
(
    input  logic       cpu_valid,
    input  logic       dbg_valid,
    input  arb_state_t state,
`ifdef DMEM_ARB_RR_EN
    input  owner_t     last_grant,
`else
    input  logic       starved,
`endif
    output logic [1:0] grant
);

    // Pick at most one requester for this cycle
    always_comb begin
        grant = 2'b00;
        if (state == ST_DBG_LOCKED) begin
            // Debug owns the memory; the CPU waits until the lock drops
            grant[GNT_DBG] = dbg_valid;
        end else if (cpu_valid && dbg_valid) begin
`ifdef DMEM_ARB_RR_EN
            if (last_grant == OWN_DBG) begin
                grant[GNT_CPU] = 1'b1;
            end else begin
                grant[GNT_DBG] = 1'b1;
            end
`else
            if (starved) begin
                grant[GNT_DBG] = 1'b1;
            end else begin
                grant[GNT_CPU] = 1'b1;
            end
`endif
        end else begin
            grant[GNT_CPU] = cpu_valid;
            grant[GNT_DBG] = dbg_valid;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the single-port dmem between the CPU
// load/store port and the debug/loader port.
// Build option DMEM_ARB_RR_EN selects round-robin contention handling;
// undefined (default) gives CPU fixed priority with a MAX_WAIT starvation
// guard for the debug port. Lock behaviour is the same in both builds.
//
// Handshake: a request transfers in the cycle where valid && ready.
// ready is a combinational function of both valids and the registered
// arbiter state, is never high for both ports at once, and valid must not
// be derived from ready. An accepted request drives mem_* in the same
// cycle; an accepted read returns rvalid/rdata exactly one cycle later on
// the issuing port only.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cpu_valid,
    output logic                  cpu_ready,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic [WSTRB_W-1:0]    cpu_wstrb,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,

    input  logic                  dbg_valid,
    output logic                  dbg_ready,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    input  logic [WSTRB_W-1:0]    dbg_wstrb,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    input  logic                  dbg_lock,

    output logic                  mem_en,
    output logic [WSTRB_W-1:0]    mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output arb_debug_t            arb_debug
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    owner_t            last_grant_q;
    owner_t            rd_owner_q;
    owner_t            rd_owner_d;
    logic [1:0]        grant;
    logic              cpu_acc;
    logic              dbg_acc;
    logic [WAIT_W-1:0] wait_cnt_dbg;

`ifndef DMEM_ARB_RR_EN
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              starved;

    assign starved = (wait_cnt_q == WAIT_W'(MAX_WAIT));
`endif

    dmem_arb_sel u_sel (
        .cpu_valid  (cpu_valid),
        .dbg_valid  (dbg_valid),
        .state      (state_q),
`ifdef DMEM_ARB_RR_EN
        .last_grant (last_grant_q),
`else
        .starved    (starved),
`endif
        .grant      (grant)
    );

    // While reset is low nothing is offered to either port, even before
    // the first clock edge has cleared the state registers.
    assign cpu_ready = reset & grant[GNT_CPU];
    assign dbg_ready = reset & grant[GNT_DBG];
    assign cpu_acc   = cpu_valid & cpu_ready;
    assign dbg_acc   = dbg_valid & dbg_ready;

    // Steer the accepted request (if any) onto the memory port
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dbg_acc) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we ? dbg_wstrb : '0;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else if (cpu_acc) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we ? cpu_wstrb : '0;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    // Lock state transitions: only an accepted debug access can move it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_UNLOCKED: begin
                if (dbg_acc && dbg_lock) begin
                    state_d = ST_DBG_LOCKED;
                end
            end
            ST_DBG_LOCKED: begin
                if (dbg_acc && !dbg_lock) begin
                    state_d = ST_UNLOCKED;
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
    end

    // Which port (if any) is owed read data next cycle
    always_comb begin
        rd_owner_d = OWN_NONE;
        if (dbg_acc && !dbg_we) begin
            rd_owner_d = OWN_DBG;
        end else if (cpu_acc && !cpu_we) begin
            rd_owner_d = OWN_CPU;
        end
    end

    // Arbiter registers: lock state, last winner and read-response owner
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_UNLOCKED;
            last_grant_q <= OWN_CPU;
            rd_owner_q   <= OWN_NONE;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
            if (dbg_acc) begin
                last_grant_q <= OWN_DBG;
            end else if (cpu_acc) begin
                last_grant_q <= OWN_CPU;
            end
        end
    end

`ifndef DMEM_ARB_RR_EN
    // Count consecutive cycles the debug port asked and was refused
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt_q <= '0;
        end else if (dbg_valid && !dbg_ready) begin
            if (!starved) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
        end else begin
            wait_cnt_q <= '0;
        end
    end

    assign wait_cnt_dbg = wait_cnt_q;
`else
    assign wait_cnt_dbg = '0;
`endif

    // Read response: gated by reset so a read in flight when reset falls
    // never surfaces, and the non-owning port always sees zeros.
    assign cpu_rvalid = reset & (rd_owner_q == OWN_CPU);
    assign dbg_rvalid = reset & (rd_owner_q == OWN_DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

    assign arb_debug.state      = state_q;
    assign arb_debug.last_grant = last_grant_q;
    assign arb_debug.rd_owner   = rd_owner_q;
    assign arb_debug.wait_cnt   = wait_cnt_dbg;

endmodule
